instr_line_buffer: RTL and testbench

Instruction-side line buffer between the fetch stage and the memory controller (mem_ctrl host port). Fetch presents a word address each cycle. Hits return the 32-bit instruction combinationally; misses stall fetch while a 512-bit line is read from mem_ctrl and written into a small direct-mapped array. The block replaces the behavioural instruction memory model at fetch's instruction port.

---
 rtl/instr_line_buffer.sv | 183 ++++++++++++++++++
 tb/tb_instr_line_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_line_buffer.sv
// -----------------------------------------------------------------------------
// instr_line_buffer
//
// Direct-mapped instruction line buffer that sits between fetch and the
// mem_ctrl host port. A hit returns the addressed 32-bit word in the same
// cycle. A miss stalls fetch while a 64-byte line is read from mem_ctrl and
// written into the array.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   addr            fetch byte address (addr[1:0] ignored)
//   en              fetch request valid
//   inv             invalidate all lines (single-cycle pulse)
//   data_out        instruction word at addr (0 unless hit)
//   done            data_out valid this cycle
//   stall           miss in progress; fetch holds addr
//   DataIn_host     line data from mem_ctrl
//   rd_valid_host   DataIn_host valid this cycle
//   tx_done_host    mem_ctrl transaction complete
//   DataOut_host    write data to mem_ctrl (always 0, read-only client)
//   AddrOut_host    line-aligned request address
//   op_host         00 idle, 01 read
//   hit_cnt         saturating count of hit cycles
//   miss_cnt        saturating count of line fills started
// -----------------------------------------------------------------------------
module instr_line_buffer #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic             en,
    input  logic             inv,
    output logic [31:0]      data_out,
    output logic             done,
    output logic             stall,
    input  logic [511:0]     DataIn_host,
    input  logic             rd_valid_host,
    input  logic             tx_done_host,
    output logic [511:0]     DataOut_host,
    output logic [31:0]      AddrOut_host,
    output logic [1:0]       op_host,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 26 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_FILL
    } state_e;

    // Control state
    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [25:0]          miss_line_q, miss_line_d;   // miss address bits [31:6]
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

    // Line storage (no reset needed: guarded by valid_q)
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [511:0]         line_q [NUM_LINES];

    // Address decomposition
    logic [3:0]           offset;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [IDX_W-1:0]     miss_idx;
    logic [TAG_W-1:0]     miss_tag;
    logic                 unused_addr_lsb;

    assign offset          = addr[5:2];
    assign idx             = addr[6 +: IDX_W];
    assign tag             = addr[31 -: TAG_W];
    assign miss_idx        = miss_line_q[0 +: IDX_W];
    assign miss_tag        = miss_line_q[25 -: TAG_W];
    assign unused_addr_lsb = ^addr[1:0];

    // Lookup
    logic hit;
    logic miss;
    logic fill_wr;

    assign hit     = (state_q == S_IDLE) && en && valid_q[idx] && (tag_q[idx] == tag);
    assign miss    = (state_q == S_IDLE) && en && !hit;
    assign fill_wr = (state_q == S_REQ) && rd_valid_host;

    assign data_out     = hit ? line_q[idx][{offset, 5'b00000} +: 32] : '0;
    assign done         = hit;
    // Raised combinationally on the detecting cycle so fetch holds addr at once.
    assign stall        = (state_q != S_IDLE) || miss;
    assign DataOut_host = '0;
    assign AddrOut_host = {miss_line_q, 6'b000000};
    assign op_host      = op_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        miss_line_d = miss_line_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        // inv clears everything; a same-cycle fill write re-sets its own line below.
        valid_d     = inv ? '0 : valid_q;

        if (hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    miss_line_d = addr[31:6];
                    state_d     = S_REQ;
                    op_d        = 2'b01;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_REQ: begin
                if (rd_valid_host) begin
                    valid_d[miss_idx] = 1'b1;
                    if (tx_done_host) begin
                        state_d = S_FILL;
                        op_d    = 2'b00;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (tx_done_host) begin
                    state_d = S_FILL;
                    op_d    = 2'b00;
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                op_d    = 2'b00;
            end
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            miss_line_q <= '0;
            valid_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            miss_line_q <= miss_line_d;
            valid_q     <= valid_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Line array write
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            line_q[miss_idx] <= DataIn_host;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_instr_line_buffer.sv
module tb_instr_line_buffer;

    logic         clk;
    logic         rst_n;
    logic [31:0]  addr;
    logic         en;
    logic         inv;
    logic [31:0]  data_out;
    logic         done;
    logic         stall;
    logic [511:0] DataIn_host;
    logic         rd_valid_host;
    logic         tx_done_host;
    logic [511:0] DataOut_host;
    logic [31:0]  AddrOut_host;
    logic [1:0]   op_host;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int errors;
    int checks;

    instr_line_buffer #(.NUM_LINES(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .en           (en),
        .inv          (inv),
        .data_out     (data_out),
        .done         (done),
        .stall        (stall),
        .DataIn_host  (DataIn_host),
        .rd_valid_host(rd_valid_host),
        .tx_done_host (tx_done_host),
        .DataOut_host (DataOut_host),
        .AddrOut_host (AddrOut_host),
        .op_host      (op_host),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one complete miss: cycle 0 presents addr, rd_valid at cycle 1+lat,
    // tx_done at cycle 1+lat+gap. Returns what it observed; callers compare.
    task automatic serve_miss(input logic [31:0] a, input int lat, input int gap,
                              input logic [31:0] base,
                              output logic stall0, output logic [1:0] op_seen,
                              output logic [31:0] addr_seen, output int hit_cyc,
                              output logic [31:0] data_seen);
        tick;
        inv = 1'b0; en = 1'b1; addr = a;
        #2;
        stall0 = stall; op_seen = 2'b11; addr_seen = 32'hFFFF_FFFF;
        hit_cyc = -1; data_seen = 32'hDEAD_BEEF;
        for (int c = 1; c <= 60; c++) begin
            tick;
            rd_valid_host = (c == 1 + lat);
            tx_done_host  = (c == 1 + lat + gap);
            DataIn_host   = mk_line(base);
            #2;
            if (c == 1) begin
                op_seen   = op_host;
                addr_seen = AddrOut_host;
            end
            if (done === 1'b1) begin
                hit_cyc   = c;
                data_seen = data_out;
                break;
            end
        end
        rd_valid_host = 1'b0;
        tx_done_host  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; addr = '0; inv = 1'b0;
        rd_valid_host = 1'b0; tx_done_host = 1'b0; DataIn_host = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        checks++; if (op_host !== 2'b00) begin errors++; $display("FAIL rst_op: got %b want 00", op_host); end
        checks++; if (AddrOut_host !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", AddrOut_host); end
        checks++; if (DataOut_host !== '0) begin errors++; $display("FAIL rst_dout_host: nonzero, want 0"); end
        checks++; if (hit_cnt !== 32'd0) begin errors++; $display("FAIL rst_hit_cnt: got %0d want 0", hit_cnt); end
        checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_miss_cnt: got %0d want 0", miss_cnt); end
        checks++; if (done !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_done_stall: got %b%b want 00", done, stall); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", data_out); end
    endtask

    task automatic test_cold_miss;
        tick; en = 1'b1; addr = 32'h0000_0008; #2;
        checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cold_c0_stall: stall=%b done=%b want 1/0", stall, done); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL cold_c0_data: got %h want 0", data_out); end
        tick; #2;
        checks++; if (op_host !== 2'b01) begin errors++; $display("FAIL cold_c1_op: got %b want 01", op_host); end
        checks++; if (AddrOut_host !== 32'h0) begin errors++; $display("FAIL cold_c1_addr: got %h want 0", AddrOut_host); end
        tick; #2;
        tick; #2;
        checks++; if (op_host !== 2'b01 || stall !== 1'b1) begin errors++; $display("FAIL cold_c3_op: op=%b stall=%b want 01/1", op_host, stall); end
        tick; rd_valid_host = 1'b1; tx_done_host = 1'b1; DataIn_host = mk_line(32'hA5A5_0000); #2;
        checks++; if (op_host !== 2'b01) begin errors++; $display("FAIL cold_c4_op: got %b want 01", op_host); end
        tick; rd_valid_host = 1'b0; tx_done_host = 1'b0; #2;
        checks++; if (op_host !== 2'b00 || stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cold_c5_fill: op=%b stall=%b done=%b want 00/1/0", op_host, stall, done); end
        tick; #2;
        checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL cold_c6_done: done=%b stall=%b want 1/0", done, stall); end
        checks++; if (data_out !== 32'hA5A5_0002) begin errors++; $display("FAIL cold_c6_data: got %h want a5a50002", data_out); end
        checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    endtask

    task automatic test_streaming_hits;
        for (int i = 0; i < 13; i++) begin
            tick; en = 1'b1; addr = 32'h0C + 32'(4 * i); #2;
            checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL stream_done[%0d]: done=%b stall=%b want 1/0", i, done, stall); end
            checks++; if (data_out !== 32'hA5A5_0003 + 32'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, data_out, 32'hA5A5_0003 + 32'(i)); end
            checks++; if (op_host !== 2'b00) begin errors++; $display("FAIL stream_op[%0d]: got %b want 00", i, op_host); end
        end
        tick; en = 1'b0; #2;
        checks++; if (hit_cnt !== 32'd14) begin errors++; $display("FAIL stream_hit_cnt: got %0d want 14", hit_cnt); end
        checks++; if (done !== 1'b0 || stall !== 1'b0 || data_out !== 32'h0) begin errors++; $display("FAIL idle_en0: done=%b stall=%b data=%h want 0/0/0", done, stall, data_out); end
        checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL stream_miss_cnt: got %0d want 1", miss_cnt); end
    endtask

    task automatic test_invalidate;
        logic s0; logic [1:0] op; logic [31:0] a; int hc; logic [31:0] d;
        tick; en = 1'b1; addr = 32'h4; #2;
        checks++; if (done !== 1'b1 || data_out !== 32'hA5A5_0001) begin errors++; $display("FAIL inv_pre_hit: done=%b data=%h want 1/a5a50001", done, data_out); end
        tick; en = 1'b0; inv = 1'b1; #2;
        serve_miss(32'h4, 1, 0, 32'h1111_0000, s0, op, a, hc, d);
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL inv_miss_stall: got %b want 1", s0); end
        checks++; if (op !== 2'b01 || a !== 32'h0) begin errors++; $display("FAIL inv_req: op=%b addr=%h want 01/0", op, a); end
        checks++; if (hc !== 4 || d !== 32'h1111_0001) begin errors++; $display("FAIL inv_refill: cyc=%0d data=%h want 4/11110001", hc, d); end
        checks++; if (miss_cnt !== 32'd2 || hit_cnt !== 32'd15) begin errors++; $display("FAIL inv_counters: miss=%0d hit=%0d want 2/15", miss_cnt, hit_cnt); end
    endtask

    // Split completion, with inv coinciding with the rd_valid write.
    task automatic test_split_completion;
        tick; en = 1'b1; addr = 32'h208; #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL split_c0_stall: got %b want 1", stall); end
        tick; #2;
        checks++; if (op_host !== 2'b01 || AddrOut_host !== 32'h200) begin errors++; $display("FAIL split_req: op=%b addr=%h want 01/200", op_host, AddrOut_host); end
        tick; rd_valid_host = 1'b1; inv = 1'b1; DataIn_host = mk_line(32'h2222_0000); #2;
        for (int c = 3; c <= 5; c++) begin
            tick; rd_valid_host = 1'b0; inv = 1'b0; #2;
            checks++; if (op_host !== 2'b01 || stall !== 1'b1) begin errors++; $display("FAIL split_drain[%0d]: op=%b stall=%b want 01/1", c, op_host, stall); end
        end
        tick; tx_done_host = 1'b1; #2;
        checks++; if (op_host !== 2'b01) begin errors++; $display("FAIL split_k4_op: got %b want 01", op_host); end
        tick; tx_done_host = 1'b0; #2;
        checks++; if (op_host !== 2'b00 || stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL split_fill: op=%b stall=%b done=%b want 00/1/0", op_host, stall, done); end
        tick; #2;
        checks++; if (done !== 1'b1 || data_out !== 32'h2222_0002) begin errors++; $display("FAIL split_hit: done=%b data=%h want 1/22220002", done, data_out); end
        checks++; if (miss_cnt !== 32'd3 || hit_cnt !== 32'd16) begin errors++; $display("FAIL split_counters: miss=%0d hit=%0d want 3/16", miss_cnt, hit_cnt); end
    endtask

    task automatic test_conflict_eviction;
        logic s0; logic [1:0] op; logic [31:0] a; int hc; logic [31:0] d;
        tick; en = 1'b0; rst_n = 1'b0; #2; rst_n = 1'b1; #1;
        serve_miss(32'h000, 2, 0, 32'h5000_0000, s0, op, a, hc, d);
        checks++; if (s0 !== 1'b1 || op !== 2'b01 || a !== 32'h000) begin errors++; $display("FAIL conf1_req: stall=%b op=%b addr=%h want 1/01/0", s0, op, a); end
        checks++; if (hc !== 5 || d !== 32'h5000_0000) begin errors++; $display("FAIL conf1_fill: cyc=%0d data=%h want 5/50000000", hc, d); end
        serve_miss(32'h10C, 2, 0, 32'h6000_0000, s0, op, a, hc, d);
        checks++; if (s0 !== 1'b1 || op !== 2'b01 || a !== 32'h100) begin errors++; $display("FAIL conf2_req: stall=%b op=%b addr=%h want 1/01/100", s0, op, a); end
        checks++; if (hc !== 5 || d !== 32'h6000_0003) begin errors++; $display("FAIL conf2_fill: cyc=%0d data=%h want 5/60000003", hc, d); end
        serve_miss(32'h03C, 2, 0, 32'h7000_0000, s0, op, a, hc, d);
        checks++; if (s0 !== 1'b1 || op !== 2'b01 || a !== 32'h000) begin errors++; $display("FAIL conf3_req: stall=%b op=%b addr=%h want 1/01/0", s0, op, a); end
        checks++; if (hc !== 5 || d !== 32'h7000_000F) begin errors++; $display("FAIL conf3_fill: cyc=%0d data=%h want 5/7000000f", hc, d); end
        checks++; if (miss_cnt !== 32'd3 || hit_cnt !== 32'd2) begin errors++; $display("FAIL conf_counters: miss=%0d hit=%0d want 3/2", miss_cnt, hit_cnt); end
    endtask

    task automatic test_reset_mid_miss;
        tick; en = 1'b1; addr = 32'h2C4; #2;
        tick; #2;
        tick; rd_valid_host = 1'b1; DataIn_host = mk_line(32'h3333_0000); #2;
        tick; rd_valid_host = 1'b0; #2;
        checks++; if (op_host !== 2'b01 || stall !== 1'b1) begin errors++; $display("FAIL rmm_drain: op=%b stall=%b want 01/1", op_host, stall); end
        #1; rst_n = 1'b0; #1;
        checks++; if (op_host !== 2'b00) begin errors++; $display("FAIL rmm_async_op: got %b want 00", op_host); end
        checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL rmm_counters: hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
        #1; rst_n = 1'b1;
        tick; #2;
        checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rmm_remiss: stall=%b done=%b want 1/0", stall, done); end
        tick; #2;
        checks++; if (op_host !== 2'b01 || AddrOut_host !== 32'h2C0 || miss_cnt !== 32'd1) begin errors++; $display("FAIL rmm_req: op=%b addr=%h miss=%0d want 01/2c0/1", op_host, AddrOut_host, miss_cnt); end
        tick; rd_valid_host = 1'b1; tx_done_host = 1'b1; DataIn_host = mk_line(32'h4444_0000); #2;
        tick; rd_valid_host = 1'b0; tx_done_host = 1'b0; #2;
        tick; #2;
        checks++; if (done !== 1'b1 || data_out !== 32'h4444_0001) begin errors++; $display("FAIL rmm_hit: done=%b data=%h want 1/44440001", done, data_out); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_cold_miss;
        test_streaming_hits;
        test_invalidate;
        test_split_completion;
        test_conflict_eviction;
        test_reset_mid_miss;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
